// File: rtl/decode_bundle_queue_pkg.sv
// Shared fetch/decode definitions: bundle geometry, decode packet layout
// and the default depth of the decode bundle queue.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DEC_PKT_SIZE
`define DEC_PKT_SIZE 32
`endif

package decode_bundle_queue_pkg;

  localparam int unsigned FETCH_WIDTH_C   = `FETCH_WIDTH;
  localparam int unsigned DEC_PKT_SIZE_C  = `DEC_PKT_SIZE;
  localparam int unsigned DEC_QUEUE_DEPTH = 4;

  // One decode packet; the MSB is the packet valid bit.
  typedef logic [DEC_PKT_SIZE_C-1:0] decPkt_t;

  // A fetch bundle: lane i sits at bits [i*DEC_PKT_SIZE_C +: DEC_PKT_SIZE_C].
  typedef decPkt_t [FETCH_WIDTH_C-1:0] decBundle_t;

endpackage

// File: rtl/decode_bundle_queue_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the bundle FIFO. Depth need not be a
// power of two: pointers wrap by comparing against DEPTH-1.
module bundle_fifo_ctrl
  import decode_bundle_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEC_QUEUE_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1),
  parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  // Wrap-aware pointer increment.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok_s = push_i & (count_q != FULL_CNT);
  assign pop_ok_s  = pop_i  & (count_q != CNT_W'(0));

  // Next-state for pointers and count; flush dominates push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == CNT_W'(0));

endmodule

// File: rtl/decode_bundle_queue.sv
// Decode-side bundle queue: captures registered fetch bundles, presents the
// head bundle to decode under ready/valid, and back-pressures fetch when full.
// Stall is a pure function of the registered count, so there is no
// combinational path from either handshake input to stall_o.
module decode_bundle_queue
  import decode_bundle_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_C,
  parameter int unsigned PKT_W       = DEC_PKT_SIZE_C,
  parameter int unsigned DEPTH       = DEC_QUEUE_DEPTH,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         fs2Ready_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0] decPacket_i,
  output logic                         stall_o,
  input  logic                         decReady_i,
  output logic                         bundleValid_o,
  output logic [FETCH_WIDTH*PKT_W-1:0] decPacket_o,
  output logic [FETCH_WIDTH-1:0]       laneValid_o,
  output logic [CNT_W-1:0]             occupancy_o,
  output logic [31:0]                  stallCycles_o
);

  localparam int unsigned BW    = FETCH_WIDTH * PKT_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BW-1:0]          mem_q [DEPTH];
  logic [FETCH_WIDTH-1:0] in_lane_valid_s;
  logic [FETCH_WIDTH-1:0] head_lane_valid_s;
  logic [BW-1:0]          head_s;
  logic [PTR_W-1:0]       wr_ptr_s, rd_ptr_s;
  logic [CNT_W-1:0]       count_s;
  logic                   full_s, empty_s;
  logic                   push_s, pop_s;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  // Extract per-lane valid bits of the incoming bundle.
  always_comb begin
    in_lane_valid_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      in_lane_valid_s[i] = decPacket_i[i*PKT_W + PKT_W - 1];
    end
  end

  // Bundles with no valid lane are dropped rather than queued.
  assign push_s = fs2Ready_i & ~full_s & ~flush_i & (|in_lane_valid_s);
  assign pop_s  = ~empty_s & decReady_i & ~flush_i;

  bundle_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .wr_ptr_o (wr_ptr_s),
    .rd_ptr_o (rd_ptr_s),
    .count_o  (count_s),
    .full_o   (full_s),
    .empty_o  (empty_s)
  );

  // Bundle storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= decPacket_i;
    end
  end

  // Head bundle, forced to zero when the queue is empty.
  always_comb begin
    head_s = '0;
    if (!empty_s) begin
      head_s = mem_q[rd_ptr_s];
    end else begin
      head_s = '0;
    end
  end

  // Per-lane valid bits of the (already masked) head bundle.
  always_comb begin
    head_lane_valid_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      head_lane_valid_s[i] = head_s[i*PKT_W + PKT_W - 1];
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (full_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall-cycle counter register; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o       = full_s;
  assign bundleValid_o = ~empty_s;
  assign decPacket_o   = head_s;
  assign laneValid_o   = head_lane_valid_s & {FETCH_WIDTH{~empty_s}};
  assign occupancy_o   = count_s;
  assign stallCycles_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_bundle_queue.sv
// Self-checking bench for decode_bundle_queue: a cycle-level queue model
// acts as scoreboard; each scenario task adds its own targeted checks.
module tb_decode_bundle_queue;

  localparam int unsigned FW    = 4;
  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned BW    = FW * PW;

  logic          clk;
  logic          reset;
  logic          flush_r;
  logic          fs2_r;
  logic [BW-1:0] pkt_r;
  logic          dec_ready_r;
  logic          stall_o;
  logic          bundleValid_o;
  logic [BW-1:0] decPacket_o;
  logic [FW-1:0] laneValid_o;
  logic [CW-1:0] occupancy_o;
  logic [31:0]   stallCycles_o;

  int            assert_cnt = 0;
  int            fail_cnt   = 0;

  logic [BW-1:0] model_q [$];
  logic [BW-1:0] src_q   [$];
  logic [7:0]    popped_q [$];
  logic [31:0]   exp_sc;
  logic          saw_stall;
  int            max_occ;

  decode_bundle_queue #(
    .FETCH_WIDTH (FW),
    .PKT_W       (PW),
    .DEPTH       (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_r),
    .fs2Ready_i    (fs2_r),
    .decPacket_i   (pkt_r),
    .stall_o       (stall_o),
    .decReady_i    (dec_ready_r),
    .bundleValid_o (bundleValid_o),
    .decPacket_o   (decPacket_o),
    .laneValid_o   (laneValid_o),
    .occupancy_o   (occupancy_o),
    .stallCycles_o (stallCycles_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // Lane i: {valid, 15'b0, tag, lane index}.
  function automatic logic [BW-1:0] make_bundle(input logic [7:0] tag, input logic [FW-1:0] lanes);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < FW; i++) begin
      b[i*PW +: PW] = {lanes[i], 15'd0, tag, 8'(i)};
    end
    return b;
  endfunction

  function automatic logic [FW-1:0] lanes_of(input logic [BW-1:0] b);
    logic [FW-1:0] l;
    for (int i = 0; i < FW; i++) begin
      l[i] = b[i*PW + PW - 1];
    end
    return l;
  endfunction

  // One clock of scoreboard operation; entered and left just after a negedge.
  task automatic step();
    logic          exp_stall, exp_valid, do_push, do_pop, src_adv;
    logic [BW-1:0] exp_head;
    fs2_r = (src_q.size() != 0);
    pkt_r = fs2_r ? src_q[0] : '0;
    #1;
    exp_stall = (model_q.size() == DEPTH);
    exp_valid = (model_q.size() != 0);
    exp_head  = exp_valid ? model_q[0] : '0;
    assert_cnt++;
    if (stall_o !== exp_stall) begin
      fail_cnt++;
      $display("FAIL sb_stall: got %b expected %b at %0t", stall_o, exp_stall, $time);
    end
    assert_cnt++;
    if (bundleValid_o !== exp_valid) begin
      fail_cnt++;
      $display("FAIL sb_valid: got %b expected %b at %0t", bundleValid_o, exp_valid, $time);
    end
    assert_cnt++;
    if (decPacket_o !== exp_head) begin
      fail_cnt++;
      $display("FAIL sb_head: got %h expected %h at %0t", decPacket_o, exp_head, $time);
    end
    assert_cnt++;
    if (laneValid_o !== lanes_of(exp_head)) begin
      fail_cnt++;
      $display("FAIL sb_lanes: got %b expected %b at %0t", laneValid_o, lanes_of(exp_head), $time);
    end
    assert_cnt++;
    if (occupancy_o !== CW'(model_q.size())) begin
      fail_cnt++;
      $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy_o, model_q.size(), $time);
    end
    if (stall_o === 1'b1) saw_stall = 1'b1;
    if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);
    do_push = fs2_r & ~exp_stall & ~flush_r & (|lanes_of(pkt_r));
    do_pop  = exp_valid & dec_ready_r & ~flush_r;
    src_adv = fs2_r & (~exp_stall | flush_r);
    if (do_pop) popped_q.push_back(decPacket_o[15:8]);
    @(posedge clk);
    if (exp_stall && (exp_sc != 32'hFFFF_FFFF)) exp_sc = exp_sc + 32'd1;
    if (flush_r) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(pkt_r);
    end
    if (src_adv) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      assert_cnt++;
      if ({bundleValid_o, stall_o, occupancy_o, decPacket_o} !== '0) begin
        fail_cnt++;
        $display("FAIL reset_hold: valid=%b stall=%b occ=%0d pkt=%h expected all 0",
                 bundleValid_o, stall_o, occupancy_o, decPacket_o);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
    end
    assert_cnt++;
    if ({bundleValid_o, stall_o, occupancy_o, decPacket_o, stallCycles_o} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_idle: valid=%b stall=%b occ=%0d sc=%0d expected all 0",
               bundleValid_o, stall_o, occupancy_o, stallCycles_o);
    end
  endtask

  task automatic test_fill_to_full();
    int guard;
    popped_q.delete();
    dec_ready_r = 1'b0;
    for (int t = 1; t <= 6; t++) src_q.push_back(make_bundle(8'(t), 4'hF));
    for (int c = 0; c < 4; c++) step();
    assert_cnt++;
    if (occupancy_o !== 3'd4 || stall_o !== 1'b1) begin
      fail_cnt++;
      $display("FAIL fill_full: occ=%0d stall=%b expected occ=4 stall=1", occupancy_o, stall_o);
    end
    step();
    step();
    dec_ready_r = 1'b1;
    guard = 0;
    while ((model_q.size() != 0 || src_q.size() != 0) && guard < 30) begin
      step();
      guard++;
    end
    assert_cnt++;
    if (guard >= 30) begin
      fail_cnt++;
      $display("FAIL fill_drain_timeout: got %0d cycles expected < 30", guard);
    end
    assert_cnt++;
    if (popped_q.size() != 6) begin
      fail_cnt++;
      $display("FAIL fill_pop_count: got %0d expected 6", popped_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        assert_cnt++;
        if (popped_q[i] !== 8'(i + 1)) begin
          fail_cnt++;
          $display("FAIL fill_order[%0d]: got %0d expected %0d", i, popped_q[i], i + 1);
        end
      end
    end
    assert_cnt++;
    if (stallCycles_o !== exp_sc || stallCycles_o < 32'd2) begin
      fail_cnt++;
      $display("FAIL fill_stall_cycles: got %0d expected %0d (at least 2)", stallCycles_o, exp_sc);
    end
  endtask

  task automatic test_streaming();
    logic in_order;
    popped_q.delete();
    saw_stall   = 1'b0;
    max_occ     = 0;
    dec_ready_r = 1'b1;
    for (int t = 1; t <= 20; t++) src_q.push_back(make_bundle(8'(8'h20 + t), 4'hF));
    for (int c = 0; c < 21; c++) step();
    assert_cnt++;
    if (popped_q.size() != 20) begin
      fail_cnt++;
      $display("FAIL stream_pops: got %0d expected 20 in 21 cycles", popped_q.size());
    end
    in_order = (popped_q.size() == 20);
    for (int i = 0; i < popped_q.size(); i++) begin
      if (popped_q[i] !== 8'(8'h21 + i)) in_order = 1'b0;
    end
    assert_cnt++;
    if (!in_order) begin
      fail_cnt++;
      $display("FAIL stream_order: got out-of-order or missing tags expected 0x21..0x34");
    end
    assert_cnt++;
    if (max_occ > 1 || saw_stall) begin
      fail_cnt++;
      $display("FAIL stream_occ_stall: max_occ=%0d stall_seen=%b expected <=1 and 0", max_occ, saw_stall);
    end
  endtask

  task automatic test_flush();
    int pops_before;
    dec_ready_r = 1'b0;
    for (int t = 1; t <= 3; t++) src_q.push_back(make_bundle(8'(8'h50 + t), 4'hF));
    for (int c = 0; c < 3; c++) step();
    assert_cnt++;
    if (occupancy_o !== 3'd3) begin
      fail_cnt++;
      $display("FAIL flush_pre_occ: got %0d expected 3", occupancy_o);
    end
    src_q.push_back(make_bundle(8'h77, 4'hF));
    dec_ready_r = 1'b1;
    flush_r     = 1'b1;
    pops_before = popped_q.size();
    step();
    flush_r = 1'b0;
    #1;
    assert_cnt++;
    if (occupancy_o !== 3'd0 || bundleValid_o !== 1'b0 || stall_o !== 1'b0) begin
      fail_cnt++;
      $display("FAIL flush_clear: occ=%0d valid=%b stall=%b expected 0 0 0", occupancy_o, bundleValid_o, stall_o);
    end
    for (int c = 0; c < 3; c++) step();
    assert_cnt++;
    if (popped_q.size() != pops_before) begin
      fail_cnt++;
      $display("FAIL flush_no_leak: got %0d pops after flush expected 0", popped_q.size() - pops_before);
    end
  endtask

  task automatic test_empty_lane_filter();
    dec_ready_r = 1'b0;
    src_q.push_back(make_bundle(8'h40, 4'b0000));
    src_q.push_back(make_bundle(8'h41, 4'b0101));
    step();
    step();
    #1;
    assert_cnt++;
    if (laneValid_o !== 4'b0101 || occupancy_o !== 3'd1) begin
      fail_cnt++;
      $display("FAIL lane_filter: lanes=%b occ=%0d expected 0101 and 1", laneValid_o, occupancy_o);
    end
    assert_cnt++;
    if (decPacket_o[15:8] !== 8'h41) begin
      fail_cnt++;
      $display("FAIL lane_filter_tag: got %h expected 41", decPacket_o[15:8]);
    end
    dec_ready_r = 1'b1;
    step();
    step();
  endtask

  task automatic test_async_reset();
    dec_ready_r = 1'b0;
    src_q.push_back(make_bundle(8'h61, 4'hF));
    src_q.push_back(make_bundle(8'h62, 4'hF));
    step();
    step();
    assert_cnt++;
    if (occupancy_o !== 3'd2) begin
      fail_cnt++;
      $display("FAIL areset_pre_occ: got %0d expected 2", occupancy_o);
    end
    #2;
    reset = 1'b0;
    #1;
    assert_cnt++;
    if ({bundleValid_o, stall_o, occupancy_o, decPacket_o, laneValid_o, stallCycles_o} !== '0) begin
      fail_cnt++;
      $display("FAIL areset_immediate: valid=%b occ=%0d pkt=%h sc=%0d expected all 0",
               bundleValid_o, occupancy_o, decPacket_o, stallCycles_o);
    end
    model_q.delete();
    src_q.delete();
    exp_sc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    popped_q.delete();
    dec_ready_r = 1'b1;
    for (int t = 1; t <= 3; t++) src_q.push_back(make_bundle(8'(8'h70 + t), 4'hF));
    for (int c = 0; c < 5; c++) step();
    assert_cnt++;
    if (popped_q.size() != 3 || popped_q[0] !== 8'h71) begin
      fail_cnt++;
      $display("FAIL areset_resume: got %0d pops expected 3 starting at 71", popped_q.size());
    end
  endtask

  initial begin
    reset       = 1'b0;
    flush_r     = 1'b0;
    fs2_r       = 1'b0;
    pkt_r       = '0;
    dec_ready_r = 1'b0;
    exp_sc      = 32'd0;
    saw_stall   = 1'b0;
    max_occ     = 0;
    test_reset();
    test_fill_to_full();
    test_streaming();
    test_flush();
    test_empty_lane_filter();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
